// File: rtl/fifo_push_arbiter_pkg.sv
// fifo_arb_pkg: shared state type, grant-counter width and saturating increment for the FIFO push arbiter
package fifo_arb_pkg;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/fifo_push_arbiter_if.sv
// fifo_push_arbiter_if: requester beats, FIFO push port, grant status and grant counters
//   slave  (arbiter): takes arb_enable, req_valid/data/last, fifo_full, cnt_clr;
//                     drives req_ready, fifo_wr_en/data, grant_active, grant_id, grant_cnt
//   master (environment): the mirror image
interface fifo_push_arbiter_if import fifo_arb_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
) ();
  localparam int IDW = $clog2(NUM_REQ);
  logic                     arb_enable;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     fifo_wr_en;
  logic [DATA_W-1:0]        fifo_wr_data;
  logic                     grant_active;
  logic [IDW-1:0]           grant_id;
  logic                     cnt_clr;
  logic [NUM_REQ*CNT_W-1:0] grant_cnt;
  modport slave (
    input  arb_enable, req_valid, req_data, req_last, fifo_full, cnt_clr,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_active, grant_id, grant_cnt
  );
  modport master (
    output arb_enable, req_valid, req_data, req_last, fifo_full, cnt_clr,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_active, grant_id, grant_cnt
  );
endinterface

// File: rtl/fifo_push_arbiter_rr_pick.sv
// rr_pick: rotating priority encoder, first set req_i bit scanning upward from last_i+1 with wrap
//   req_i  : request vector      last_i : previous winner
//   any_o  : some request set    idx_o  : winning index (0 when none)
module rr_pick #(
  parameter int NUM_REQ = 2,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     last_i,
  output logic               any_o,
  output logic [IDW-1:0]     idx_o
);
  assign any_o = |req_i;
  // Scan farthest offset first so the nearest requester after last_i overwrites it.
  always_comb begin
    idx_o = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req_i[IDW'((int'(last_i) + k) % NUM_REQ)]) idx_o = IDW'((int'(last_i) + k) % NUM_REQ);
  end
endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: packet-atomic round-robin sharing of one FIFO push port among NUM_REQ requesters
//   clk_main_a0 : clock
//   rst_main_n  : asynchronous active-low reset
//   bus         : fifo_push_arbiter_if slave (requesters, FIFO push, grant status, grant counters)
module fifo_push_arbiter import fifo_arb_pkg::*; #(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int IDLE_TO   = 8
) (
  input logic                clk_main_a0,
  input logic                rst_main_n,
  fifo_push_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int BW  = $clog2(MAX_BURST + 1);
  localparam int TW  = $clog2(IDLE_TO + 1);
  arb_state_t                    state_q, state_d;
  logic [IDW-1:0]                gnt_q, gnt_d, last_q, last_d, pick_idx;
  logic [BW-1:0]                 beat_q, beat_d;
  logic [TW-1:0]                 idle_q, idle_d;
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic pick_any, granted, g_valid, idle_rel, ready_g, beat, rel, start;
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i  (bus.req_valid),
    .last_i (last_q),
    .any_o  (pick_any),
    .idx_o  (pick_idx)
  );
  always_comb begin
    granted  = state_q == ARB_GRANT;
    g_valid  = bus.req_valid[gnt_q];
    // Timeout release carries no beat, so ready is pulled low on that cycle.
    idle_rel = granted && !g_valid && idle_q == TW'(IDLE_TO - 1);
    ready_g  = granted && !bus.fifo_full && !idle_rel;
    beat     = ready_g && g_valid;
    rel      = (beat && (bus.req_last[gnt_q] || beat_q == BW'(MAX_BURST - 1))) || idle_rel;
    // Only IDLE can start a grant, which enforces the dead cycle between grants.
    start    = !granted && bus.arb_enable && pick_any;
    state_d  = start ? ARB_GRANT : rel ? ARB_IDLE : state_q;
    gnt_d    = start ? pick_idx : gnt_q;
    last_d   = rel ? gnt_q : last_q;
    beat_d   = !granted ? '0 : beat ? beat_q + 1'b1 : beat_q;
    // A full-stall with valid high is not idle time.
    idle_d   = (!granted || g_valid) ? '0 : idle_q + 1'b1;
    bus.fifo_wr_data = '0;
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q == IDW'(i)) bus.fifo_wr_data = bus.req_data[i*DATA_W +: DATA_W];
      cnt_d[i] = bus.cnt_clr ? '0 : (start && pick_idx == IDW'(i)) ? sat_inc(cnt_q[i]) : cnt_q[i];
    end
  end
  assign bus.req_ready    = ready_g ? (NUM_REQ'(1) << gnt_q) : '0;
  assign bus.fifo_wr_en   = beat;
  assign bus.grant_active = granted;
  assign bus.grant_id     = gnt_q;
  assign bus.grant_cnt    = cnt_q;
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
      beat_q  <= '0;
      idle_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      idle_q  <= idle_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: directed scenarios with hand-computed expectations for fifo_push_arbiter
module tb_fifo_push_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  fifo_push_arbiter_if #(.NUM_REQ(2), .DATA_W(32)) bus ();
  fifo_push_arbiter #(.NUM_REQ(2), .DATA_W(32), .MAX_BURST(4), .IDLE_TO(8)) dut (
    .clk_main_a0 (clk),
    .rst_main_n  (rst_n),
    .bus         (bus)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic mid;
    @(negedge clk);
  endtask
  task automatic test_reset;
    bus.arb_enable = 1'b1;
    bus.req_valid  = 2'b11;
    bus.req_last   = 2'b11;
    bus.req_data   = '0;
    bus.fifo_full  = 1'b0;
    bus.cnt_clr    = 1'b0;
    rst_n = 1'b0;
    repeat (2) mid;
    n_cmp++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b exp 00", bus.req_ready); end
    n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %b exp 0", bus.fifo_wr_en); end
    n_cmp++; if (bus.grant_active !== 1'b0) begin n_err++; $display("FAIL reset_active got %b exp 0", bus.grant_active); end
    n_cmp++; if (bus.grant_id !== 1'b0) begin n_err++; $display("FAIL reset_id got %b exp 0", bus.grant_id); end
    n_cmp++; if (bus.grant_cnt !== 32'h0) begin n_err++; $display("FAIL reset_cnt got %h exp 0", bus.grant_cnt); end
    tick;
    rst_n = 1'b1;
  endtask
  task automatic test_round_robin;
    bus.req_data = {32'hB1B1_0000, 32'hA0A0_0000};
    for (int c = 0; c < 8; c++) begin
      mid;
      n_cmp++; if (bus.fifo_wr_en !== c[0]) begin n_err++; $display("FAIL rr_wr_en c%0d got %b exp %b", c, bus.fifo_wr_en, c[0]); end
      if (c[0]) begin
        n_cmp++; if (bus.grant_id !== c[1]) begin n_err++; $display("FAIL rr_id c%0d got %b exp %b", c, bus.grant_id, c[1]); end
        n_cmp++; if (bus.req_ready !== (c[1] ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rr_ready c%0d got %b", c, bus.req_ready); end
        n_cmp++; if (bus.fifo_wr_data !== (c[1] ? 32'hB1B1_0000 : 32'hA0A0_0000)) begin n_err++; $display("FAIL rr_data c%0d got %h", c, bus.fifo_wr_data); end
      end
      tick;
    end
    bus.req_valid = 2'b00;
    mid;
    n_cmp++; if (bus.grant_cnt !== 32'h0002_0002) begin n_err++; $display("FAIL rr_cnt got %h exp 00020002", bus.grant_cnt); end
    tick;
  endtask
  task automatic test_burst;
    logic [31:0] exp_d [11];
    int exp_c [11];
    logic exp_id [11];
    int k0, np;
    logic done1;
    exp_d  = '{32'h100, 32'h101, 32'h102, 32'h103, 32'hB1, 32'h104, 32'h105, 32'h106, 32'h107, 32'h108, 32'h109};
    exp_c  = '{1, 2, 3, 4, 6, 8, 9, 10, 11, 13, 14};
    exp_id = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    k0 = 0;
    np = 0;
    done1 = 1'b0;
    for (int c = 0; c < 18; c++) begin
      bus.req_valid = {~done1, k0 < 10};
      bus.req_last  = {1'b1, k0 == 9};
      bus.req_data  = {32'hB1, 32'h100 + k0};
      mid;
      if (bus.fifo_wr_en) begin
        if (np < 11) begin
          n_cmp++; if (bus.grant_id !== exp_id[np]) begin n_err++; $display("FAIL burst_id push%0d got %b exp %b", np, bus.grant_id, exp_id[np]); end
          n_cmp++; if (bus.fifo_wr_data !== exp_d[np]) begin n_err++; $display("FAIL burst_data push%0d got %h exp %h", np, bus.fifo_wr_data, exp_d[np]); end
          n_cmp++; if (c !== exp_c[np]) begin n_err++; $display("FAIL burst_cycle push%0d got %0d exp %0d", np, c, exp_c[np]); end
        end
        np++;
      end
      if (bus.req_ready[0] && bus.req_valid[0]) k0++;
      if (bus.req_ready[1] && bus.req_valid[1]) done1 = 1'b1;
      tick;
    end
    bus.req_valid = 2'b00;
    n_cmp++; if (np !== 11) begin n_err++; $display("FAIL burst_pushes got %0d exp 11", np); end
    mid;
    n_cmp++; if (bus.grant_cnt !== 32'h0003_0005) begin n_err++; $display("FAIL burst_cnt got %h exp 00030005", bus.grant_cnt); end
    tick;
  endtask
  task automatic test_full_stall;
    int k0;
    logic exp_en;
    k0 = 0;
    for (int c = 0; c < 9; c++) begin
      bus.req_valid = {1'b0, c < 8};
      bus.req_last  = {1'b0, k0 == 4};
      bus.req_data  = {32'h0, 32'hD0 + k0};
      bus.fifo_full = c >= 2 && c <= 4;
      mid;
      exp_en = c == 1 || (c >= 5 && c <= 7);
      n_cmp++; if (bus.fifo_wr_en !== exp_en) begin n_err++; $display("FAIL full_wr_en c%0d got %b exp %b", c, bus.fifo_wr_en, exp_en); end
      n_cmp++; if (bus.req_ready !== {1'b0, exp_en}) begin n_err++; $display("FAIL full_ready c%0d got %b exp 0%b", c, bus.req_ready, exp_en); end
      n_cmp++; if (bus.grant_active !== (c >= 1 && c <= 7)) begin n_err++; $display("FAIL full_active c%0d got %b", c, bus.grant_active); end
      if (exp_en) begin
        n_cmp++; if (bus.fifo_wr_data !== 32'hD0 + (c == 1 ? 0 : c - 4)) begin n_err++; $display("FAIL full_data c%0d got %h", c, bus.fifo_wr_data); end
      end
      if (bus.req_ready[0] && bus.req_valid[0]) k0++;
      tick;
    end
    bus.fifo_full = 1'b0;
    mid;
    n_cmp++; if (bus.grant_cnt !== 32'h0003_0006) begin n_err++; $display("FAIL full_cnt got %h exp 00030006", bus.grant_cnt); end
    tick;
  endtask
  task automatic test_idle_timeout;
    for (int c = 0; c < 11; c++) begin
      bus.req_valid = {c == 0, c >= 1};
      bus.req_last  = 2'b01;
      bus.req_data  = {32'h11, 32'h22};
      mid;
      n_cmp++; if (bus.grant_active !== ((c >= 1 && c <= 8) || c == 10)) begin n_err++; $display("FAIL idle_active c%0d got %b", c, bus.grant_active); end
      n_cmp++; if (bus.fifo_wr_en !== (c == 10)) begin n_err++; $display("FAIL idle_wr_en c%0d got %b", c, bus.fifo_wr_en); end
      if (c == 7) begin
        n_cmp++; if (bus.req_ready !== 2'b10) begin n_err++; $display("FAIL idle_ready7 got %b exp 10", bus.req_ready); end
      end
      if (c == 8) begin
        n_cmp++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL idle_ready_rel got %b exp 00", bus.req_ready); end
      end
      if (c == 10) begin
        n_cmp++; if (bus.grant_id !== 1'b0) begin n_err++; $display("FAIL idle_next_id got %b exp 0", bus.grant_id); end
        n_cmp++; if (bus.fifo_wr_data !== 32'h22) begin n_err++; $display("FAIL idle_next_data got %h exp 22", bus.fifo_wr_data); end
      end
      tick;
    end
    bus.req_valid = 2'b00;
    mid;
    n_cmp++; if (bus.grant_cnt !== 32'h0004_0007) begin n_err++; $display("FAIL idle_cnt got %h exp 00040007", bus.grant_cnt); end
    tick;
  endtask
  task automatic test_enable_off;
    for (int c = 0; c < 7; c++) begin
      bus.arb_enable = c == 0;
      bus.req_valid  = {c >= 1, c <= 3};
      bus.req_last   = {1'b1, c == 3};
      bus.req_data   = {32'h77, 32'hE0 + c};
      mid;
      n_cmp++; if (bus.fifo_wr_en !== (c >= 1 && c <= 3)) begin n_err++; $display("FAIL en_wr_en c%0d got %b", c, bus.fifo_wr_en); end
      n_cmp++; if (bus.grant_active !== (c >= 1 && c <= 3)) begin n_err++; $display("FAIL en_active c%0d got %b", c, bus.grant_active); end
      if (c >= 1 && c <= 3) begin
        n_cmp++; if (bus.fifo_wr_data !== 32'hE0 + c) begin n_err++; $display("FAIL en_data c%0d got %h", c, bus.fifo_wr_data); end
      end
      tick;
    end
    bus.req_valid  = 2'b00;
    bus.arb_enable = 1'b1;
    mid;
    n_cmp++; if (bus.grant_cnt !== 32'h0004_0008) begin n_err++; $display("FAIL en_cnt got %h exp 00040008", bus.grant_cnt); end
    tick;
  endtask
  task automatic test_saturate_clear;
    logic [31:0] exp_cnt [4];
    exp_cnt = '{32'h0004_FFFF, 32'h0004_FFFF, 32'h0000_0000, 32'h0000_0001};
    force dut.cnt_q = 32'h0004_FFFE;
    #1;
    release dut.cnt_q;
    for (int c = 0; c < 8; c++) begin
      bus.req_valid = 2'b01;
      bus.req_last  = 2'b01;
      bus.req_data  = {32'h0, 32'h55};
      bus.cnt_clr   = c == 4;
      mid;
      if (c[0]) begin
        n_cmp++; if (bus.grant_cnt !== exp_cnt[c/2]) begin n_err++; $display("FAIL sat_cnt c%0d got %h exp %h", c, bus.grant_cnt, exp_cnt[c/2]); end
        n_cmp++; if (bus.grant_active !== 1'b1) begin n_err++; $display("FAIL sat_active c%0d got %b exp 1", c, bus.grant_active); end
      end
      tick;
    end
    bus.req_valid = 2'b00;
    bus.cnt_clr   = 1'b0;
  endtask
  task automatic test_reset_mid_grant;
    bus.req_valid = 2'b11;
    bus.req_last  = 2'b00;
    bus.req_data  = {32'h99, 32'h88};
    mid;
    tick;
    mid;
    n_cmp++; if (bus.grant_id !== 1'b1 || bus.grant_active !== 1'b1) begin n_err++; $display("FAIL rstm_pre got id %b active %b exp 1 1", bus.grant_id, bus.grant_active); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL rstm_ready got %b exp 00", bus.req_ready); end
    n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL rstm_wr_en got %b exp 0", bus.fifo_wr_en); end
    n_cmp++; if (bus.grant_active !== 1'b0) begin n_err++; $display("FAIL rstm_active got %b exp 0", bus.grant_active); end
    n_cmp++; if (bus.grant_id !== 1'b0) begin n_err++; $display("FAIL rstm_id got %b exp 0", bus.grant_id); end
    n_cmp++; if (bus.grant_cnt !== 32'h0) begin n_err++; $display("FAIL rstm_cnt got %h exp 0", bus.grant_cnt); end
    tick;
    rst_n = 1'b1;
    mid;
    n_cmp++; if (bus.grant_active !== 1'b0) begin n_err++; $display("FAIL rstm_idle got %b exp 0", bus.grant_active); end
    tick;
    mid;
    n_cmp++; if (bus.grant_id !== 1'b0) begin n_err++; $display("FAIL rstm_first_id got %b exp 0", bus.grant_id); end
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_err++; $display("FAIL rstm_first_ready got %b exp 01", bus.req_ready); end
    tick;
    bus.req_valid = 2'b00;
  endtask
  initial begin
    test_reset;
    test_round_robin;
    test_burst;
    test_full_stall;
    test_idle_timeout;
    test_enable_off;
    test_saturate_clear;
    test_reset_mid_grant;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout reached before the end of the sequence");
    $fatal(1);
  end
endmodule
